// File: rtl/lab_seq_pkg.sv
// Shared types and constants for the lab pin sequencer.
package lab_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CAPTURE,
        HOLD,
        DONE
    } seq_state_t;

    localparam int unsigned CODE_W_C   = 4;
    localparam int unsigned CNT_W_C    = 8;
    localparam int unsigned SIG_INIT_C = 0;

    // Highest code of a sweep for a given code width.
    function automatic int unsigned code_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    localparam int unsigned CODE_MAX_C = code_max(CODE_W_C);

endpackage

// File: rtl/lab_settle_counter.sv
// Settle-time counter: counts while enabled, clear has priority, flags the last settle cycle.
module lab_settle_counter
    import lab_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc_c
);

    localparam logic [CNT_W_C-1:0] TC_VAL = CNT_W_C'(SETTLE_CYCLES - 1);

    logic [CNT_W_C-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W_C'(1);
        end
    end

    assign tc_c = (cnt == TC_VAL);

endmodule

// File: rtl/lab_pin_sequencer.sv
// Sweeps all codes onto the lab circuit inputs and captures its output per code.
// Define LAB_PIN_SEQUENCER_SIGNATURE_EN to add a rotate-XOR signature of the captured results.
module lab_pin_sequencer
    import lab_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CODE_W        = 4,
    parameter int unsigned RESULT_W      = 8
) (
    input  logic                GlobalClock,
    input  logic                ResetN,
    input  logic                start,
    input  logic                abort,
    input  logic                single_step,
    input  logic                step,
    output logic [CODE_W-1:0]   code_out,
    input  logic [RESULT_W-1:0] result_in,
    output logic                result_valid,
    output logic [CODE_W-1:0]   result_code,
    output logic [RESULT_W-1:0] result_data,
    output logic                busy,
    output logic                done
`ifdef LAB_PIN_SEQUENCER_SIGNATURE_EN
    ,
    output logic [RESULT_W-1:0] signature
`endif
);

    localparam logic [CODE_W-1:0] CODE_MAX = CODE_W'(code_max(CODE_W));

    seq_state_t state;
    logic       mode;
    logic       tc_c;
    logic       abort_c;

    // Abort only acts outside IDLE, so start wins when both arrive in IDLE.
    assign abort_c = abort && (state != IDLE);

    lab_settle_counter #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk  (GlobalClock),
        .rst_n(ResetN),
        .clr  (abort_c || (state != SETTLE)),
        .inc  (state == SETTLE),
        .tc_c (tc_c)
    );

    always_ff @(posedge GlobalClock or negedge ResetN) begin
        if (!ResetN) begin
            state        <= IDLE;
            mode         <= 1'b0;
            code_out     <= '0;
            result_valid <= 1'b0;
            result_code  <= '0;
            result_data  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            done         <= 1'b0;
            if (abort_c) begin
                state    <= IDLE;
                code_out <= '0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= SETTLE;
                            code_out <= '0;
                            mode     <= single_step;
                            busy     <= 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (tc_c) begin
                            state <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        result_data  <= result_in;
                        result_code  <= code_out;
                        result_valid <= 1'b1;
                        if (code_out == CODE_MAX) begin
                            state <= DONE;
                        end else if (mode) begin
                            state <= HOLD;
                        end else begin
                            code_out <= code_out + CODE_W'(1);
                            state    <= SETTLE;
                        end
                    end
                    HOLD: begin
                        if (step) begin
                            code_out <= code_out + CODE_W'(1);
                            state    <= SETTLE;
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef LAB_PIN_SEQUENCER_SIGNATURE_EN
    // Signature folds each captured result in; cleared on start and on abort.
    always_ff @(posedge GlobalClock or negedge ResetN) begin
        if (!ResetN) begin
            signature <= RESULT_W'(SIG_INIT_C);
        end else if (abort_c || (state == IDLE && start)) begin
            signature <= RESULT_W'(SIG_INIT_C);
        end else if (state == CAPTURE) begin
            signature <= {signature[RESULT_W-2:0], signature[RESULT_W-1]} ^ result_in;
        end
    end
`endif

endmodule

// File: tb/tb_lab_pin_sequencer.sv
// Randomized self-checking bench for lab_pin_sequencer; expectations come from sweep timing arithmetic.
module tb_lab_pin_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       single_step;
    logic       step;
    logic [3:0] code_out;
    logic [7:0] result_in;
    logic       result_valid;
    logic [3:0] result_code;
    logic [7:0] result_data;
    logic       busy;
    logic       done;
`ifdef LAB_PIN_SEQUENCER_SIGNATURE_EN
    logic [7:0] signature;
`endif

    int total = 0;
    int bad   = 0;

    lab_pin_sequencer #(
        .SETTLE_CYCLES(4),
        .CODE_W       (4),
        .RESULT_W     (8)
    ) dut (
        .GlobalClock (clk),
        .ResetN      (rst_n),
        .start       (start),
        .abort       (abort),
        .single_step (single_step),
        .step        (step),
        .code_out    (code_out),
        .result_in   (result_in),
        .result_valid(result_valid),
        .result_code (result_code),
        .result_data (result_data),
        .busy        (busy),
        .done        (done)
`ifdef LAB_PIN_SEQUENCER_SIGNATURE_EN
        ,
        .signature   (signature)
`endif
    );

    // Model of the lab circuit: upper nibble is the inverted code.
    assign result_in = {~code_out, code_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_result(input int c);
        logic [3:0] cc;
        cc = 4'(c);
        return {~cc, cc};
    endfunction

    function automatic logic [7:0] model_signature();
        logic [7:0] s;
        s = 8'h00;
        for (int c = 0; c < 16; c++) s = {s[6:0], s[7]} ^ model_result(c);
        return s;
    endfunction

    task automatic start_sweep(input logic ss);
        single_step = ss;
        abort = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_busy", 32'(busy), 32'd1);
        check_eq("start_code", 32'(code_out), 32'd0);
`ifdef LAB_PIN_SEQUENCER_SIGNATURE_EN
        check_eq("start_sig_clear", 32'(signature), 32'd0);
`endif
    endtask

    // Free sweep: capture of code k lands 5*(k+1) edges after start, done at 81.
    task automatic free_sweep();
        int exp_code;
        logic exp_valid;
        start_sweep(1'b0);
        for (int n = 1; n <= 90; n++) begin
            start       = (n <= 81) ? 1'($urandom_range(0, 1)) : 1'b0;
            step        = 1'($urandom_range(0, 1));
            single_step = 1'($urandom_range(0, 1));
            tick();
            exp_valid = (n % 5 == 0) && (n <= 80);
            exp_code  = (n / 5 > 15) ? 15 : n / 5;
            check_eq("free_valid", 32'(result_valid), 32'(exp_valid));
            check_eq("free_done", 32'(done), 32'(n == 81));
            check_eq("free_busy", 32'(busy), 32'(n <= 80));
            check_eq("free_code_out", 32'(code_out), 32'(exp_code));
            if (exp_valid) begin
                check_eq("free_result_code", 32'(result_code), 32'(n / 5 - 1));
                check_eq("free_result_data", 32'(result_data), 32'(model_result(n / 5 - 1)));
            end
`ifdef LAB_PIN_SEQUENCER_SIGNATURE_EN
            if (n == 81) check_eq("free_signature", 32'(signature), 32'(model_signature()));
`endif
        end
        start = 1'b0;
        step = 1'b0;
        single_step = 1'b0;
    endtask

    task automatic single_step_sweep();
        int w;
        int hold;
        start_sweep(1'b1);
        w = 1;
        for (int k = 0; k < 16; k++) begin
            for (int i = 1; i <= 4; i++) begin
                step = (i < w);
                single_step = 1'($urandom_range(0, 1));
                tick();
                check_eq("ss_settle_valid", 32'(result_valid), 32'd0);
                check_eq("ss_settle_code", 32'(code_out), 32'(k));
            end
            step = 1'b0;
            tick();
            check_eq("ss_valid", 32'(result_valid), 32'd1);
            check_eq("ss_result_code", 32'(result_code), 32'(k));
            check_eq("ss_result_data", 32'(result_data), 32'(model_result(k)));
            if (k == 15) begin
                tick();
                check_eq("ss_done", 32'(done), 32'd1);
                check_eq("ss_done_busy", 32'(busy), 32'd0);
`ifdef LAB_PIN_SEQUENCER_SIGNATURE_EN
                check_eq("ss_signature", 32'(signature), 32'(model_signature()));
`endif
            end else begin
                hold = (k == 3) ? 20 : $urandom_range(0, 6);
                for (int h = 0; h < hold; h++) begin
                    tick();
                    check_eq("ss_hold_valid", 32'(result_valid), 32'd0);
                    check_eq("ss_hold_code", 32'(code_out), 32'(k));
                    check_eq("ss_hold_busy", 32'(busy), 32'd1);
                end
                w = $urandom_range(1, 3);
                step = 1'b1;
                tick();
                check_eq("ss_step_code", 32'(code_out), 32'(k + 1));
                check_eq("ss_step_valid", 32'(result_valid), 32'd0);
            end
        end
        step = 1'b0;
    endtask

    task automatic abort_at(input int n_ab, input string tag, input int exp_rcode);
        int pulses;
        start_sweep(1'b0);
        repeat (n_ab) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq({tag, "_valid"}, 32'(result_valid), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_code_out"}, 32'(code_out), 32'd0);
        check_eq({tag, "_result_code"}, 32'(result_code), 32'(exp_rcode));
        check_eq({tag, "_result_data"}, 32'(result_data), 32'(model_result(exp_rcode)));
`ifdef LAB_PIN_SEQUENCER_SIGNATURE_EN
        check_eq({tag, "_sig_clear"}, 32'(signature), 32'd0);
`endif
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            pulses += int'(result_valid) + int'(done) + int'(busy);
        end
        check_eq({tag, "_quiet"}, 32'(pulses), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        single_step = 1'b0;
        step = 1'b0;
        #23;
        check_eq("rst_code_out", 32'(code_out), 32'd0);
        check_eq("rst_valid", 32'(result_valid), 32'd0);
        check_eq("rst_result_code", 32'(result_code), 32'd0);
        check_eq("rst_result_data", 32'(result_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        free_sweep();
        single_step_sweep();
        abort_at(35 + $urandom_range(0, 3), "abort_settle7", 6);
        abort_at(79, "abort_capture15", 14);
        abort_at(80, "abort_done", 15);

        // Start and abort together in IDLE: start wins, the held abort then stops it.
        abort = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("idle_start_abort_busy", 32'(busy), 32'd1);
        tick();
        check_eq("idle_start_abort_stop", 32'(busy), 32'd0);
        abort = 1'b0;

        // Asynchronous reset between edges while holding.
        start_sweep(1'b1);
        repeat (6) tick();
        check_eq("pre_rst_hold_code", 32'(code_out), 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_code_out", 32'(code_out), 32'd0);
        check_eq("arst_valid", 32'(result_valid), 32'd0);
        check_eq("arst_result_code", 32'(result_code), 32'd0);
        check_eq("arst_result_data", 32'(result_data), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
`ifdef LAB_PIN_SEQUENCER_SIGNATURE_EN
        check_eq("arst_sig", 32'(signature), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        free_sweep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
